sync_ram_param: RTL and testbench
=================================

Name: sync_ram_param

Overview:
Parametrised, single-clock, single-port synchronous RAM. It is the successor to the small combinational 4-word RAM.
- Registered read with 1-cycle latency and a valid strobe.
- Self-clearing initialisation sequence after reset, with a busy flag.
- Tri-stated output bus.
It sits beside the constant ROM and feeds operands to the pipelined float adder over a shared 32-bit bus.

Parameters:
WIDTH, 32, data word width in bits
DEPTH, 16, number of words (any value 2..2**ADDR_W, not necessarily a power of two)
ADDR_W, 4, address width; must satisfy 2**ADDR_W >= DEPTH

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
en  in  1  request strobe; sampled at posedge, ignored while busy=1
RW  in  1  1 = write, 0 = read
OE  in  1  read enable (for acceptance) and output-drive enable
addr  in  ADDR_W  word address
in  in  WIDTH  write data
out  out  WIDTH  read data; high-Z when not driven
valid  out  1  out carries read data this cycle
busy  out  1  initialisation in progress; requests ignored

Behaviour:
- One clock; reset is synchronous and active-high.
- State machine: INIT, READY.
- Reset: posedge with rst=1 sets state=INIT, clear counter cnt=0, busy=1, valid=0, internal read register rd_q=0. out is high-Z.
- rst=1 during INIT or READY (mid-operation): restarts INIT from cnt=0. Any pending valid is dropped next edge.
- INIT: each posedge with rst=0 writes data[cnt]=0.
  - If cnt==DEPTH-1: state goes to READY and busy goes to 0 on the same edge. Otherwise cnt increments.
  - busy is therefore high for exactly DEPTH edges after rst falls.
  - en, RW, OE and addr are ignored in INIT.
- READY, posedge with en=1, RW=1: data[addr]=in; valid goes to 0.
- READY, posedge with en=1, RW=0, OE=1: rd_q=data[addr]; valid goes to 1 for exactly one cycle (1-cycle read latency).
- READY, en=1, RW=0, OE=0: no operation; valid goes to 0.
- READY, en=0: no operation; valid goes to 0; contents unchanged.
- Back-to-back reads on consecutive cycles: valid stays high; rd_q updates every cycle.
- Read-after-write to the same address on the next cycle returns the new data.
- Out-of-range address (addr >= DEPTH, only possible when DEPTH is not a power of two):
  - Write is dropped; no location changes.
  - Read returns rd_q=0 with valid=1.
- out = rd_q when valid=1 and OE=1 (current-cycle OE). Otherwise out = all-Z. The output is combinational from valid, OE and rd_q.
- Contents are undefined only between power-up and the end of the first INIT. No read is accepted before then.

Optional Feature:
Macro RAM_WRITE_THROUGH_EN.
- Defined: an accepted write also loads rd_q=in and sets valid=1 for one cycle. The written word appears on out the next cycle if OE=1.
  - An out-of-range write still sets valid=1, with rd_q=in, while the array is unchanged.
- Undefined: writes set valid=0 and leave rd_q unchanged.

Test Plan:
1. Reset, DEPTH=16: rst=1 for 1 edge, then 0 -> busy=1 for exactly 16 edges, then 0. Read all 16 addresses -> each returns 32'h00000000 with valid=1 one cycle after request.
2. Write addr 2 = 32'h3F800000 and addr 3 = 32'h3C449BA6, then read 3, 2 back-to-back -> out=32'h3C449BA6 then 32'h3F800000 on consecutive cycles, valid high both cycles.
3. Read addr 5 with OE=1, then drop OE to 0 in the valid cycle -> out=Z while valid=1. OE=0 on accept -> no valid pulse.
4. Write 32'h41200000 to addr 7, assert rst at cycle 3 of the following INIT, release -> busy restarts (16 more edges); read addr 7 -> 32'h00000000.
5. DEPTH=10, ADDR_W=4: write 32'hDEADBEEF to addr 12 -> addr 0..9 unchanged; read addr 12 -> out=0, valid=1.
6. RAM_WRITE_THROUGH_EN defined: write 32'h40400000 to addr 1 with OE=1 -> next cycle valid=1, out=32'h40400000. Undefined: valid=0, out=Z.

Source files
------------

// File: rtl/sync_ram_param.sv
// Parametrised single-port synchronous RAM: registered read with valid strobe,
// self-clearing INIT after reset, tri-stated output. Option: RAM_WRITE_THROUGH_EN.
module sync_ram_param #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              RW,
    input  logic              OE,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  in,
    output logic [WIDTH-1:0]  out,
    output logic              valid,
    output logic              busy
);

    typedef enum logic {INIT, READY} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state, state_next;
    logic [ADDR_W-1:0] cnt, cnt_next;
    logic [WIDTH-1:0]  rd_q, rd_next;
    logic              valid_next;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  wdata;
    logic              in_range;

    logic [WIDTH-1:0]  mem [DEPTH];

    // Extra bit keeps the compare correct when DEPTH == 2**ADDR_W.
    assign in_range = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        rd_next    = rd_q;
        valid_next = 1'b0;
        we         = 1'b0;
        waddr      = addr;
        wdata      = in;
        unique case (state)
            INIT: begin
                we    = 1'b1;
                waddr = cnt;
                wdata = '0;
                if (cnt == LAST) begin
                    state_next = READY;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            READY: begin
                if (en) begin
                    if (RW) begin
                        we = in_range;
`ifdef RAM_WRITE_THROUGH_EN
                        valid_next = 1'b1;
                        rd_next    = in;
`endif
                    end else if (OE) begin
                        valid_next = 1'b1;
                        rd_next    = in_range ? mem[addr] : '0;
                    end
                end
            end
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
            valid <= 1'b0;
            rd_q  <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            valid <= valid_next;
            rd_q  <= rd_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && we) begin
            mem[waddr] <= wdata;
        end
    end

    assign busy = (state == INIT);
    assign out  = (valid && OE) ? rd_q : 'z;

endmodule

// File: tb/tb_sync_ram_param.sv
// Randomised self-checking bench for sync_ram_param (DEPTH=16 and DEPTH=10 instances)
// against an array-based behavioural model of the RAM.
module tb_sync_ram_param;

    logic        clk;
    logic        rst;
    logic        en_i   [2];
    logic        rw_i   [2];
    logic        oe_i   [2];
    logic [3:0]  addr_i [2];
    logic [31:0] din_i  [2];
    wire  [31:0] out0, out1;
    logic        valid0, valid1, busy0, busy1;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // model state
    int          dep  [2] = '{16, 10};
    logic [31:0] mem  [2][16];
    logic        mv   [2];
    logic [31:0] mrd  [2];
    int          left [2];

    sync_ram_param #(.WIDTH(32), .DEPTH(16), .ADDR_W(4)) dut16 (
        .clk(clk), .rst(rst), .en(en_i[0]), .RW(rw_i[0]), .OE(oe_i[0]),
        .addr(addr_i[0]), .in(din_i[0]), .out(out0), .valid(valid0), .busy(busy0)
    );

    sync_ram_param #(.WIDTH(32), .DEPTH(10), .ADDR_W(4)) dut10 (
        .clk(clk), .rst(rst), .en(en_i[1]), .RW(rw_i[1]), .OE(oe_i[1]),
        .addr(addr_i[1]), .in(din_i[1]), .out(out1), .valid(valid1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_out(input int k);
        logic [31:0] z;
        z = 'z;
        return (mv[k] && oe_i[k]) ? mrd[k] : z;
    endfunction

    // One clock edge: model advanced from the inputs seen at the edge, then #1 settle.
    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                left[k] = dep[k];
                mv[k]   = 1'b0;
                mrd[k]  = '0;
                for (int i = 0; i < 16; i++) mem[k][i] = '0;
            end else if (left[k] > 0) begin
                left[k] = left[k] - 1;
                mv[k]   = 1'b0;
            end else if (en_i[k] && rw_i[k]) begin
                if (int'(addr_i[k]) < dep[k]) mem[k][addr_i[k]] = din_i[k];
`ifdef RAM_WRITE_THROUGH_EN
                mv[k]  = 1'b1;
                mrd[k] = din_i[k];
`else
                mv[k]  = 1'b0;
`endif
            end else if (en_i[k] && oe_i[k]) begin
                mv[k]  = 1'b1;
                mrd[k] = (int'(addr_i[k]) < dep[k]) ? mem[k][addr_i[k]] : 32'h0;
            end else begin
                mv[k] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic drive(input int k, input logic e, input logic rw, input logic oe,
                         input logic [3:0] a, input logic [31:0] d);
        en_i[k] = e; rw_i[k] = rw; oe_i[k] = oe; addr_i[k] = a; din_i[k] = d;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 4'd0, 32'h0);
        drive(1, 0, 0, 0, 4'd0, 32'h0);
    endtask

    task automatic test_reset();
        int n;
        idle();
        rst = 1'b1;
        tick();
        total++;
        if (busy0 !== 1'b1 || valid0 !== 1'b0) begin
            bad++;
            $display("FAIL reset_state busy=%b valid=%b want busy=1 valid=0", busy0, valid0);
        end
        total++;
        if (out0 !== exp_out(0)) begin
            bad++;
            $display("FAIL reset_out got=%h want=%h", out0, exp_out(0));
        end
        rst = 1'b0;
        n = 0;
        while (busy0 === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (n != 16) begin
            bad++;
            $display("FAIL init_busy_edges got=%0d want=16", n);
        end
        total++;
        if (busy1 !== 1'b0) begin
            bad++;
            $display("FAIL init_busy10 got=%b want=0", busy1);
        end
        for (int a = 0; a < 16; a++) begin
            drive(0, 1, 0, 1, 4'(a), 32'h0);
            tick();
            total++;
            if (valid0 !== 1'b1 || out0 !== 32'h0) begin
                bad++;
                $display("FAIL init_zero[%0d] valid=%b out=%h want valid=1 out=00000000",
                         a, valid0, out0);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_write_read();
        drive(0, 1, 1, 0, 4'd2, 32'h3F800000); tick();
        drive(0, 1, 1, 0, 4'd3, 32'h3C449BA6); tick();
        drive(0, 1, 0, 1, 4'd3, 32'h0);        tick();
        total++;
        if (valid0 !== 1'b1 || out0 !== 32'h3C449BA6) begin
            bad++;
            $display("FAIL rd_addr3 valid=%b out=%h want 1/3c449ba6", valid0, out0);
        end
        drive(0, 1, 0, 1, 4'd2, 32'h0);        tick();
        total++;
        if (valid0 !== 1'b1 || out0 !== 32'h3F800000) begin
            bad++;
            $display("FAIL rd_addr2 valid=%b out=%h want 1/3f800000", valid0, out0);
        end
        // read-after-write on the next cycle
        drive(0, 1, 1, 0, 4'd9, 32'h12345678); tick();
        drive(0, 1, 0, 1, 4'd9, 32'h0);        tick();
        total++;
        if (valid0 !== 1'b1 || out0 !== 32'h12345678) begin
            bad++;
            $display("FAIL raw_addr9 valid=%b out=%h want 1/12345678", valid0, out0);
        end
        idle();
        tick();
    endtask

    task automatic test_oe();
        drive(0, 1, 0, 1, 4'd5, 32'h0); tick();
        drive(0, 0, 0, 0, 4'd0, 32'h0); #1;
        total++;
        if (valid0 !== 1'b1 || out0 !== exp_out(0) || mv[0] !== 1'b1) begin
            bad++;
            $display("FAIL oe_drop valid=%b out=%h want valid=1 out=%h", valid0, out0, exp_out(0));
        end
        drive(0, 1, 0, 0, 4'd5, 32'h0); tick();
        oe_i[0] = 1'b1; #1;
        total++;
        if (valid0 !== 1'b0 || out0 !== exp_out(0)) begin
            bad++;
            $display("FAIL oe0_accept valid=%b out=%h want valid=0 out=%h", valid0, out0, exp_out(0));
        end
        idle();
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 2; k++)
                drive(k, 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 3) != 0),
                      4'($urandom), $urandom);
            tick();
            for (int k = 0; k < 2; k++) begin
                total++;
                if ((k == 0 ? valid0 : valid1) !== mv[k] || (k == 0 ? out0 : out1) !== exp_out(k)) begin
                    bad++;
                    $display("FAIL random[%0d] dut%0d valid=%b out=%h want valid=%b out=%h", c, k,
                             k == 0 ? valid0 : valid1, k == 0 ? out0 : out1, mv[k], exp_out(k));
                end
            end
        end
        idle();
        tick();
    endtask

    task automatic test_reset_restart();
        int n;
        drive(0, 1, 1, 0, 4'd7, 32'h41200000); tick();
        idle();
        rst = 1'b1; tick();
        rst = 1'b0; tick(); tick(); tick();
        total++;
        if (busy0 !== 1'b1) begin
            bad++;
            $display("FAIL restart_busy_mid got=%b want=1", busy0);
        end
        rst = 1'b1; tick();
        rst = 1'b0;
        n = 0;
        while (busy0 === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (n != 16) begin
            bad++;
            $display("FAIL restart_busy_edges got=%0d want=16", n);
        end
        drive(0, 1, 0, 1, 4'd7, 32'h0); tick();
        total++;
        if (valid0 !== 1'b1 || out0 !== 32'h0) begin
            bad++;
            $display("FAIL restart_addr7 valid=%b out=%h want 1/00000000", valid0, out0);
        end
        idle();
        tick();
    endtask

    task automatic test_out_of_range();
        drive(1, 1, 1, 0, 4'd12, 32'hDEADBEEF); tick();
        for (int a = 0; a < 10; a++) begin
            drive(1, 1, 0, 1, 4'(a), 32'h0); tick();
            total++;
            if (valid1 !== 1'b1 || out1 !== mem[1][a]) begin
                bad++;
                $display("FAIL oor_keep[%0d] valid=%b out=%h want 1/%h", a, valid1, out1, mem[1][a]);
            end
        end
        drive(1, 1, 0, 1, 4'd12, 32'h0); tick();
        total++;
        if (valid1 !== 1'b1 || out1 !== 32'h0) begin
            bad++;
            $display("FAIL oor_read valid=%b out=%h want 1/00000000", valid1, out1);
        end
        idle();
        tick();
    endtask

    task automatic test_write_through();
        logic [31:0] z;
        z = 'z;
        drive(0, 1, 1, 1, 4'd1, 32'h40400000); tick();
        idle();
        oe_i[0] = 1'b1; #1;
        total++;
`ifdef RAM_WRITE_THROUGH_EN
        if (valid0 !== 1'b1 || out0 !== 32'h40400000) begin
            bad++;
            $display("FAIL write_through valid=%b out=%h want 1/40400000", valid0, out0);
        end
`else
        if (valid0 !== 1'b0 || out0 !== z) begin
            bad++;
            $display("FAIL write_no_through valid=%b out=%h want 0/%h", valid0, out0, z);
        end
`endif
        idle();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_write_read();
        test_oe();
        test_random();
        test_reset_restart();
        test_out_of_range();
        test_write_through();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
